// File: rtl/i2c_master_byte.sv
// Single-master I2C byte controller: START, 7-bit address, one data byte
// (write or read) and STOP, with a start/done handshake and NACK reporting.
module i2c_master_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       sys_clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       scl_o,
  inout  wire        sda_io
);
  localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

  if (QTR < 2) begin : g_qtr_check
    $error("i2c_master_byte: quarter-bit length %0d is below 2 clocks", QTR);
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP, S_DONE
  } state_t;

  state_t          state, next_state;
  logic [QW-1:0]   qcnt;
  logic [1:0]      phase;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [7:0]      wdata;
  logic            rw_q;
  logic            sda_smp;
  logic            sda_low;
  logic            tick, smp, slot_end;

  assign tick     = (qcnt == QW'(QTR - 1));
  assign smp      = tick && (phase == 2'd2);
  assign slot_end = tick && (phase == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (start_i) next_state = S_START;
      S_START: if (slot_end) next_state = S_ADDR;
      S_ADDR:  if (slot_end && bit_cnt == 3'd0) next_state = S_ACK1;
      S_ACK1:  if (slot_end) next_state = sda_smp ? S_STOP : S_DATA;
      S_DATA:  if (slot_end && bit_cnt == 3'd0) next_state = S_ACK2;
      S_ACK2:  if (slot_end) next_state = S_STOP;
      S_STOP:  if (slot_end) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      qcnt      <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      wdata     <= 8'h00;
      rw_q      <= 1'b0;
      sda_smp   <= 1'b0;
      ack_err_o <= 1'b0;
      rd_data_o <= 8'h00;
    end else if (state == S_IDLE) begin
      qcnt  <= '0;
      phase <= 2'd0;
      if (start_i) begin
        shift     <= {dev_addr_i, rw_i};
        wdata     <= wr_data_i;
        rw_q      <= rw_i;
        bit_cnt   <= 3'd7;
        ack_err_o <= 1'b0;
      end
    end else if (state != S_DONE) begin
      qcnt <= tick ? '0 : qcnt + QW'(1);
      if (tick) phase <= phase + 2'd1;
      if (smp)  sda_smp <= sda_io;
      if (slot_end) begin
        // Sampled bit shifts in every byte slot; only reads keep the result.
        if (state == S_ADDR || state == S_DATA) begin
          shift   <= {shift[6:0], sda_smp};
          bit_cnt <= bit_cnt - 3'd1;
        end
        if (state == S_ACK1) begin
          shift <= wdata;
          if (sda_smp) ack_err_o <= 1'b1;
        end
        if (state == S_ACK2 && !rw_q && sda_smp) ack_err_o <= 1'b1;
        if (state == S_STOP && rw_q) rd_data_o <= shift;
      end
    end
  end

  always_comb begin
    scl_o   = 1'b1;
    sda_low = 1'b0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    unique case (state)
      S_IDLE:  busy_o = 1'b0;
      S_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      S_START: sda_low = phase[1];
      S_ADDR: begin
        scl_o   = phase[1];
        sda_low = !shift[7];
      end
      S_DATA: begin
        scl_o   = phase[1];
        sda_low = !rw_q && !shift[7];
      end
      S_ACK1, S_ACK2: scl_o = phase[1];
      S_STOP: begin
        scl_o   = (phase != 2'd0);
        sda_low = !phase[1];
      end
      default: ;
    endcase
  end

  // Open-drain: the master only ever pulls SDA low or lets it float.
  assign sda_io = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a behavioural slave at address 7'h27
// that latches written bytes and returns its latched byte on reads.
module tb_i2c_master_byte;
  localparam logic [6:0] SLV_ADDR = 7'h27;

  logic       sys_clk_i = 1'b0;
  logic       rst_n_i   = 1'b1;
  logic       start_i   = 1'b0;
  logic       rw_i      = 1'b0;
  logic [6:0] dev_addr_i = 7'h00;
  logic [7:0] wr_data_i  = 8'h00;
  logic [7:0] rd_data_o;
  logic       busy_o, done_o, ack_err_o, scl_o;
  wire        sda;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Slave model state
  logic       s_low = 1'b0;
  logic       scl_d = 1'b1, sda_d = 1'b1;
  logic       active = 1'b0, match = 1'b0, rd = 1'b0;
  logic [7:0] sh = 8'h00, bus0 = 8'h00, bus1 = 8'h00, slave_out = 8'h00;
  logic       ack0 = 1'b0, ack1 = 1'b0;
  int         k = 0, byte_no = 0;
  int         n_rise = 0, n_start = 0, n_stop = 0;

  pullup (sda);
  assign sda = s_low ? 1'b0 : 1'bz;

  i2c_master_byte dut (
    .sys_clk_i  (sys_clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .rw_i       (rw_i),
    .dev_addr_i (dev_addr_i),
    .wr_data_i  (wr_data_i),
    .rd_data_o  (rd_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ack_err_o  (ack_err_o),
    .scl_o      (scl_o),
    .sda_io     (sda)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // Slave watches the bus on the falling clock edge, away from DUT updates.
  always @(negedge sys_clk_i) begin
    scl_d <= scl_o;
    sda_d <= sda;
    if (scl_o && scl_d && sda_d && !sda) begin
      active  <= 1'b1;
      k       <= 0;
      byte_no <= 0;
      s_low   <= 1'b0;
      n_start <= n_start + 1;
    end else if (scl_o && scl_d && !sda_d && sda) begin
      active <= 1'b0;
      s_low  <= 1'b0;
      n_stop <= n_stop + 1;
    end else if (scl_o && !scl_d) begin
      n_rise <= n_rise + 1;
      if (active) begin
        if (k < 8) sh <= {sh[6:0], sda};
        else if (byte_no == 0) ack0 <= sda;
        else ack1 <= sda;
        k <= k + 1;
      end
    end else if (!scl_o && scl_d && active) begin
      if (k == 8) begin
        if (byte_no == 0) begin
          bus0  <= sh;
          match <= (sh[7:1] == SLV_ADDR);
          rd    <= sh[0];
          s_low <= (sh[7:1] == SLV_ADDR);
        end else begin
          bus1  <= sh;
          s_low <= match && !rd;
          if (match && !rd) slave_out <= sh;
        end
      end else if (k == 9) begin
        k       <= 0;
        byte_no <= byte_no + 1;
        s_low   <= (byte_no == 0) && match && rd && !slave_out[7];
      end else begin
        s_low <= (byte_no == 1) && match && rd && !slave_out[7-k];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    @(posedge sys_clk_i); #1;
    start_i = 1'b1; rw_i = rw; dev_addr_i = addr; wr_data_i = data;
    @(posedge sys_clk_i); #1;
    start_i = 1'b0;
  endtask

  // Counts clock edges after acceptance until done_o; optional stray start pulse.
  task automatic wait_done(input int pulse_at, output int cycles);
    cycles = 0;
    while (!done_o && cycles < 20000) begin
      @(posedge sys_clk_i); #1;
      cycles = cycles + 1;
      if (cycles == pulse_at) begin
        start_i = 1'b1; rw_i = 1'b1; dev_addr_i = 7'h12; wr_data_i = 8'h00;
      end else begin
        start_i = 1'b0;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk_i); #1;
    end
  endtask

  initial begin
    int cyc, rise0, start0, stop0;

    // Reset
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_scl", 32'(scl_o), 1);
    check("rst_sda", 32'(sda), 1);
    check("rst_busy", 32'(busy_o), 0);
    repeat (3) @(posedge sys_clk_i);
    #1 rst_n_i = 1'b1;
    run_cycles(2);
    check("idle_scl", 32'(scl_o), 1);
    check("idle_sda", 32'(sda), 1);
    check("idle_busy", 32'(busy_o), 0);
    check("idle_done", 32'(done_o), 0);
    check("idle_ack_err", 32'(ack_err_o), 0);
    check("idle_rd_data", 32'(rd_data_o), 32'h00);

    // Write 8'hA5 to 7'h27
    rise0 = n_rise; start0 = n_start; stop0 = n_stop;
    start_txn(1'b0, 7'h27, 8'hA5);
    check("wr_busy_after_accept", 32'(busy_o), 1);
    wait_done(-1, cyc);
    check("wr_cycles", 32'(cyc), 10000);
    check("wr_done", 32'(done_o), 1);
    check("wr_busy_at_done", 32'(busy_o), 0);
    check("wr_ack_err", 32'(ack_err_o), 0);
    check("wr_addr_byte", 32'(bus0), 32'h4E);
    check("wr_data_byte", 32'(bus1), 32'hA5);
    check("wr_addr_ack", 32'(ack0), 0);
    check("wr_data_ack", 32'(ack1), 0);
    check("wr_slave_out", 32'(slave_out), 32'hA5);
    check("wr_scl_rises", 32'(n_rise - rise0), 19);
    check("wr_starts", 32'(n_start - start0), 1);
    check("wr_stops", 32'(n_stop - stop0), 1);

    // Read back from 7'h27, issued right after the write's done_o
    start_txn(1'b1, 7'h27, 8'hFF);
    check("wr_done_single_pulse", 32'(done_o), 0);
    wait_done(-1, cyc);
    check("rd_cycles", 32'(cyc), 10000);
    check("rd_addr_byte", 32'(bus0), 32'h4F);
    check("rd_bus_data", 32'(bus1), 32'hA5);
    check("rd_data", 32'(rd_data_o), 32'hA5);
    check("rd_master_nack", 32'(ack1), 1);
    check("rd_ack_err", 32'(ack_err_o), 0);

    // Write to absent 7'h12: address NACK
    rise0 = n_rise; stop0 = n_stop;
    start_txn(1'b0, 7'h12, 8'h77);
    wait_done(-1, cyc);
    check("nack_cycles", 32'(cyc), 5500);
    check("nack_ack_err", 32'(ack_err_o), 1);
    check("nack_addr_byte", 32'(bus0), 32'h24);
    check("nack_addr_ack", 32'(ack0), 1);
    check("nack_scl_rises", 32'(n_rise - rise0), 10);
    check("nack_stops", 32'(n_stop - stop0), 1);
    check("nack_slave_out", 32'(slave_out), 32'hA5);
    run_cycles(1);
    check("nack_ack_err_sticky", 32'(ack_err_o), 1);

    // Write 8'hC3 with a stray start pulse mid-transaction
    start0 = n_start;
    start_txn(1'b0, 7'h27, 8'hC3);
    check("ack_err_cleared", 32'(ack_err_o), 0);
    wait_done(2000, cyc);
    check("pulse_cycles", 32'(cyc), 10000);
    check("pulse_addr_byte", 32'(bus0), 32'h4E);
    check("pulse_data_byte", 32'(bus1), 32'hC3);
    check("pulse_slave_out", 32'(slave_out), 32'hC3);
    check("pulse_starts", 32'(n_start - start0), 1);
    // start_i during the done_o cycle must be dropped
    start_i = 1'b1; rw_i = 1'b1; dev_addr_i = 7'h27;
    @(posedge sys_clk_i); #1;
    start_i = 1'b0;
    check("done_cycle_start_busy", 32'(busy_o), 0);
    run_cycles(1);
    check("done_cycle_start_still_idle", 32'(busy_o), 0);

    // Reset during DATA slot 3 of a write of 8'h3C
    start_txn(1'b0, 7'h27, 8'h3C);
    run_cycles(6600);
    check("abort_busy_before", 32'(busy_o), 1);
    check("abort_scl_before", 32'(scl_o), 0);
    rst_n_i = 1'b0;
    #1;
    check("abort_scl", 32'(scl_o), 1);
    check("abort_sda", 32'(sda), 1);
    check("abort_busy", 32'(busy_o), 0);
    check("abort_done", 32'(done_o), 0);
    check("abort_rd_data", 32'(rd_data_o), 32'h00);
    check("abort_slave_out", 32'(slave_out), 32'hC3);
    run_cycles(2);
    rst_n_i = 1'b1;

    // Fresh write after the aborted one
    start0 = n_start;
    start_txn(1'b0, 7'h27, 8'h5A);
    wait_done(-1, cyc);
    check("post_rst_cycles", 32'(cyc), 10000);
    check("post_rst_data_byte", 32'(bus1), 32'h5A);
    check("post_rst_slave_out", 32'(slave_out), 32'h5A);
    check("post_rst_ack_err", 32'(ack_err_o), 0);
    check("post_rst_starts", 32'(n_start - start0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_master_byte.md
# i2c_master_byte

Clocked single-master I2C controller that generates START, 7-bit address, one data byte and STOP toward the board's I2C slave devices, including the address-7'h27 output-port slave. It sits between on-chip control logic (start/done handshake) and the SCL/SDA pins, directly upstream of the SCL-sampled slave. It supports one single-byte write or one single-byte read per request and reports address/data NACK.

## Interface
- CLK_FREQ, 50_000_000, sys_clk_i frequency in Hz
- I2C_FREQ, 100_000, SCL frequency in Hz; QTR = CLK_FREQ/(4*I2C_FREQ) cycles per quarter-bit (default 125); QTR < 2 is a elaboration error
- sys_clk_i  input  1  system clock; one clock domain, all logic on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- start_i  input  1  request strobe; sampled only when busy_o=0
- rw_i  input  1  0 = write, 1 = read; captured with start_i
- dev_addr_i  input  7  target address; captured with start_i
- wr_data_i  input  8  write byte; captured with start_i
- rd_data_o  output  8  byte read; valid from done_o of a read, held until next read completes
- busy_o  output  1  transaction in progress
- done_o  output  1  one-cycle pulse at transaction end
- ack_err_o  output  1  a slave NACK occurred in the last transaction; sticky until next accepted start
- scl_o  output  1  SCL, push-pull (single master, no clock stretching)
- sda_io  inout  8'b? 1  SDA, open-drain: drives 0 or 1'bz only, never 1

## Operation
- Quarter-tick counter runs 0..QTR-1 while busy; tick on wrap. Each bit slot = 4 quarters q0..q3.
- States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE.
- IDLE: scl_o=1, SDA released. start_i=1 -> capture rw_i/dev_addr_i/wr_data_i, shift register = {dev_addr_i, rw_i}, clear ack_err_o, busy_o=1 next cycle, -> START.
- START: q0–q1 SCL=1 SDA released; q2 SDA driven 0 (SCL high); q3 SCL=1; SCL falls at end of q3 -> ADDR.
- Data bit slot (ADDR, DATA, ACKx): q0 SCL=0, SDA updated at q0 entry; q1 SCL=0; q2–q3 SCL=1; SDA sampled on the last cycle of q2; SCL falls at q0 of next slot.
- ADDR: 8 slots MSB first, bit 7 counter down to 0 -> ACK1.
- ACK1: SDA released, sample. 0 -> DATA. 1 -> ack_err_o=1, -> STOP (data byte skipped).
- DATA write: drive wr_data MSB first. DATA read: SDA released, shift in sample MSB first.
- ACK2 write: release, sample slave ACK; 1 -> ack_err_o=1. ACK2 read: master releases SDA (NACK, ends read); no error flagged.
- STOP: q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2 SDA released (SCL high = STOP); q3 bus idle -> DONE.
- DONE: one cycle; done_o=1, busy_o=0 in same cycle, read: rd_data_o loaded from shift register; -> IDLE.
- start_i while busy_o=1 or in DONE cycle: ignored, no queueing.

## Timing
- Reset values: scl_o=1, SDA released, busy_o=0, done_o=0, ack_err_o=0, rd_data_o=8'h00, state IDLE, counters 0.
- Reset asserted mid-transaction: all outputs to reset values immediately (asynchronous); no STOP generated; bench must not expect bus cleanup.
- start_i accepted at cycle N -> busy_o=1 at N+1; START q0 begins N+1.
- Full transaction (no NACK): START + 18 bit slots + STOP = 20 slots * 4 * QTR cycles = 10000 cycles default; done_o at N+1+10000.
- Address NACK: START + 9 slots + STOP = 11 slots * 4 * QTR = 5500 cycles default.
- SDA never changes while SCL=1 except in START q2 and STOP q2.
- Shift/bit counter 3 bits, wrap 0->7 on byte boundary; quarter counter width $clog2(QTR).
- Back-to-back: new start_i accepted the cycle after done_o; bus idle ≥1 quarter (STOP q3) between transactions.

## Test plan
- Reset: hold rst_n_i=0, then release -> scl_o=1, SDA=z, busy_o=0, done_o=0, ack_err_o=0, rd_data_o=8'h00.
- Write 8'hA5 to 7'h27 with slave model -> bus bytes 8'h4E, 8'hA5, both ACKed; slave output = 8'hA5; done_o at 10000 cycles after accept; ack_err_o=0.
- Read from 7'h27 after previous write -> address byte 8'h4F, master NACK on ACK2, rd_data_o=8'hA5 at done_o, ack_err_o=0.
- Write to absent 7'h12 -> address NACK, no data slots, STOP, done_o at 5500 cycles, ack_err_o=1; next accepted start clears it.
- start_i pulsed mid-transaction with different addr/data -> ignored; bus shows only original bytes; single done_o.
- Assert rst_n_i during DATA slot 3 -> same-cycle scl_o=1, SDA=z, busy_o=0; a subsequent write to 7'h27 completes correctly after slave sees new START.
